chacha20_stream_xor: RTL and testbench

Initiator side of the chacha20_block start/done interface. The block holds key, nonce and block counter, and assembles the 16-word input state. It pulses start to an external chacha20_block, captures the 16-word keystream on done, and XORs it word-by-word into a valid/ready data stream. This is the encrypt/decrypt datapath that sits between a data source and the ChaCha20 core.

---
 rtl/chacha20_stream_xor_if.sv | 35 +++
 rtl/chacha20_stream_xor.sv | 154 +++++++++++++++
 tb/tb_chacha20_stream_xor.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chacha20_stream_xor_if.sv
// ============================================================================
// Module      : chacha20_stream_xor_if
// Description : Valid/ready data stream in and out of chacha20_stream_xor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface chacha20_stream_xor_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

`default_nettype wire

// File: rtl/chacha20_stream_xor.sv
// ============================================================================
// Module      : chacha20_stream_xor
// Description : Requests ChaCha20 keystream blocks from an external core and
//               XORs them word-by-word into a valid/ready data stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chacha20_stream_xor (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init,
    input  logic [255:0]         key,
    input  logic [95:0]          nonce,
    input  logic [31:0]          ctr_init,
    chacha20_stream_xor_if.slave sif,
    output logic                 core_start,
    output logic [31:0]          core_state_in [0:15],
    input  logic                 core_done,
    input  logic [31:0]          core_state_out [0:15],
    output logic [31:0]          blk_ctr,
    output logic                 busy,
    output logic                 ctr_exhausted
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ       = 3'd1,
        S_WAIT      = 3'd2,
        S_STREAM    = 3'd3,
        S_EXHAUSTED = 3'd4
    } state_t;

    localparam logic [31:0] c_sigma [0:3] = '{32'h61707865, 32'h3320646e,
                                              32'h79622d32, 32'h6b206574};

    state_t        r_state;
    state_t        w_next;
    logic [255:0]  r_key;
    logic [95:0]   r_nonce;
    logic [31:0]   r_blk_ctr;
    logic [31:0]   r_ks [0:15];
    logic [3:0]    r_idx;
    logic          r_out_valid;
    logic [31:0]   r_out_data;
    logic          r_exhausted;
    logic          r_discard;
    logic          w_in_ready;
    logic          w_accept;
    logic          w_capture;

    assign w_in_ready = (r_state == S_STREAM) && (!r_out_valid || sif.out_ready);
    // init takes priority, so a word offered in the init cycle is dropped
    assign w_accept   = sif.in_valid && w_in_ready && !init;
    assign w_capture  = (r_state == S_WAIT) && core_done && !r_discard && !init;
    // A stale done level from the previous block must fall before a new start
    assign core_start = (r_state == S_REQ) && !core_done && !r_discard && !init;

    assign sif.in_ready  = w_in_ready;
    assign sif.out_valid = r_out_valid;
    assign sif.out_data  = r_out_data;
    assign blk_ctr       = r_blk_ctr;
    assign busy          = (r_state == S_REQ) || (r_state == S_WAIT);
    assign ctr_exhausted = r_exhausted;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            core_state_in[i] = c_sigma[i];
        end
        for (int i = 0; i < 8; i++) begin
            core_state_in[4+i] = r_key[32*i +: 32];
        end
        core_state_in[12] = r_blk_ctr;
        for (int j = 0; j < 3; j++) begin
            core_state_in[13+j] = r_nonce[32*j +: 32];
        end
    end

    always_comb begin
        w_next = r_state;
        if (init) begin
            w_next = S_REQ;
        end else begin
            case (r_state)
                S_IDLE:      w_next = S_IDLE;
                S_REQ:       if (core_start) w_next = S_WAIT;
                S_WAIT:      if (w_capture) w_next = S_STREAM;
                S_STREAM: begin
                    if (w_accept && (r_idx == 4'd15)) begin
                        w_next = r_exhausted ? S_EXHAUSTED : S_REQ;
                    end
                end
                S_EXHAUSTED: w_next = S_EXHAUSTED;
                default:     w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_key       <= '0;
            r_nonce     <= '0;
            r_blk_ctr   <= '0;
            for (int i = 0; i < 16; i++) begin
                r_ks[i] <= '0;
            end
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_exhausted <= 1'b0;
            r_discard   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (init) begin
                r_key       <= key;
                r_nonce     <= nonce;
                r_blk_ctr   <= ctr_init;
                r_exhausted <= 1'b0;
                r_out_valid <= 1'b0;
                r_idx       <= '0;
                // The block in flight belongs to the old key; skip its done
                if ((r_state == S_WAIT) && !core_done) begin
                    r_discard <= 1'b1;
                end
            end else begin
                if (r_discard && core_done) begin
                    r_discard <= 1'b0;
                end
                if (w_capture) begin
                    for (int i = 0; i < 16; i++) begin
                        r_ks[i] <= core_state_out[i];
                    end
                    r_idx <= '0;
                    if (&r_blk_ctr) begin
                        r_exhausted <= 1'b1;
                    end else begin
                        r_blk_ctr <= r_blk_ctr + 32'd1;
                    end
                end
                if (w_accept) begin
                    r_out_data  <= sif.in_data ^ r_ks[r_idx];
                    r_out_valid <= 1'b1;
                    r_idx       <= r_idx + 4'd1;
                end else if (r_out_valid && sif.out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_chacha20_stream_xor.sv
// ============================================================================
// Module      : tb_chacha20_stream_xor
// Description : Scoreboard bench for chacha20_stream_xor with a ChaCha20 core model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chacha20_stream_xor;

    typedef logic [31:0] blk_t [0:15];

    logic         clk;
    logic         rst_n;
    logic         init;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  ctr_init;
    logic         core_start;
    blk_t         core_state_in;
    logic         core_done;
    blk_t         core_state_out;
    logic [31:0]  blk_ctr;
    logic         busy;
    logic         ctr_exhausted;

    chacha20_stream_xor_if sif ();

    chacha20_stream_xor dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .init           (init),
        .key            (key),
        .nonce          (nonce),
        .ctr_init       (ctr_init),
        .sif            (sif),
        .core_start     (core_start),
        .core_state_in  (core_state_in),
        .core_done      (core_done),
        .core_state_out (core_state_out),
        .blk_ctr        (blk_ctr),
        .busy           (busy),
        .ctr_exhausted  (ctr_exhausted)
    );

    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_starts = 0;
    logic [31:0]  exp_q [$];
    blk_t         last_st;
    logic [255:0] m_key;
    logic [95:0]  m_nonce;
    logic [31:0]  m_ctr;
    logic [31:0]  m_req_ctr;
    int           m_idx;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic void mk_state(input logic [255:0] k, input logic [95:0] n,
                                     input logic [31:0] c, output blk_t s);
        s[0] = 32'h61707865; s[1] = 32'h3320646e;
        s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
        s[12] = c;
        for (int j = 0; j < 3; j++) s[13+j] = n[32*j +: 32];
    endfunction

    function automatic void chacha(input blk_t s, output blk_t x);
        int qa [0:7] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int qb [0:7] = '{4, 5, 6, 7, 5, 6, 7, 4};
        int qc [0:7] = '{8, 9, 10, 11, 10, 11, 8, 9};
        int qd [0:7] = '{12, 13, 14, 15, 15, 12, 13, 14};
        int a, b, c, d;
        x = s;
        for (int r = 0; r < 10; r++) begin
            for (int q = 0; q < 8; q++) begin
                a = qa[q]; b = qb[q]; c = qc[q]; d = qd[q];
                x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
                x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 12);
                x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
                x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 7);
            end
        end
        for (int i = 0; i < 16; i++) x[i] = x[i] + s[i];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural core: done rises 20 cycles after start and is held 3 cycles
    initial begin
        blk_t st;
        blk_t res;
        core_done = 1'b0;
        for (int i = 0; i < 16; i++) core_state_out[i] = '0;
        forever begin
            @(negedge clk);
            if (rst_n && core_start) begin
                st = core_state_in;
                repeat (20) @(posedge clk);
                #1;
                chacha(st, res);
                core_state_out = res;
                core_done = 1'b1;
                repeat (3) @(posedge clk);
                #1 core_done = 1'b0;
            end
        end
    end

    // Start monitor: every request must carry the layout of the latched stream
    initial begin
        blk_t es;
        int   errs;
        forever begin
            @(negedge clk);
            if (rst_n && core_start) begin
                n_starts++;
                last_st = core_state_in;
                mk_state(m_key, m_nonce, m_req_ctr, es);
                errs = 0;
                for (int i = 0; i < 16; i++) if (core_state_in[i] !== es[i]) errs++;
                chk("start_ctr", core_state_in[12], m_req_ctr);
                chk("start_layout_errs", 32'(errs), 32'd0);
                m_req_ctr = m_req_ctr + 32'd1;
            end
        end
    end

    // Output monitor: pops the scoreboard on every transfer
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && sif.out_valid && sif.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_unexpected: got %08h expected none at %0t",
                             sif.out_data, $time);
                end else begin
                    chk("out_data", sif.out_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic do_init(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
        init = 1'b1; key = k; nonce = n; ctr_init = c;
        m_key = k; m_nonce = n; m_ctr = c; m_req_ctr = c; m_idx = 0;
        @(posedge clk);
        #1 init = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic use_hand,
                             input logic [31:0] hand, output int waits);
        blk_t s;
        blk_t ks;
        sif.in_valid = 1'b1;
        sif.in_data  = d;
        waits = 0;
        @(negedge clk);
        while (!sif.in_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!sif.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
            sif.in_valid = 1'b0;
        end else begin
            mk_state(m_key, m_nonce, m_ctr, s);
            chacha(s, ks);
            exp_q.push_back(use_hand ? hand : (d ^ ks[m_idx]));
            m_idx++;
            if (m_idx == 16) begin
                m_idx = 0;
                m_ctr = m_ctr + 32'd1;
            end
            @(posedge clk);
            #1 sif.in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || sif.out_valid) && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("drain_done", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [255:0] k1;
        int w;
        int tot;
        int starts_before;
        rst_n = 1'b0; init = 1'b0; key = '0; nonce = '0; ctr_init = '0;
        sif.in_valid = 1'b0; sif.in_data = '0; sif.out_ready = 1'b1;
        m_key = '0; m_nonce = '0; m_ctr = '0; m_req_ctr = '0; m_idx = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_in_ready", 32'(sif.in_ready), 32'd0);
        chk("rst_out_valid", 32'(sif.out_valid), 32'd0);
        chk("rst_out_data", sif.out_data, 32'd0);
        chk("rst_core_start", 32'(core_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_blk_ctr", blk_ctr, 32'd0);
        chk("rst_exhausted", 32'(ctr_exhausted), 32'd0);
        @(posedge clk);
        #1;

        // RFC 8439 2.4.2 vector, then 40 words across three blocks
        for (int i = 0; i < 32; i++) k1[8*i +: 8] = 8'(i);
        do_init(k1, {32'h00000000, 32'h4a000000, 32'h00000000}, 32'd1);
        send_word(32'h6964614c, 1'b1, 32'h9a352e6e, w);
        chk("rfc_state12", last_st[12], 32'h00000001);
        chk("rfc_state13", last_st[13], 32'h00000000);
        chk("rfc_state14", last_st[14], 32'h4a000000);
        chk("rfc_blk_ctr", blk_ctr, 32'd2);
        for (int i = 1; i < 40; i++) send_word(32'hdeadbeef ^ (32'h01010101 * i), 1'b0, '0, w);
        drain();
        chk("starts_40w", 32'(n_starts), 32'd3);

        // Backpressure mid-block, then full-rate burst to the end of the block
        send_word(32'h12345678, 1'b0, '0, w);
        sif.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(sif.in_ready), 32'd0);
            chk("bp_out_valid", 32'(sif.out_valid), 32'd1);
            chk("bp_out_data", sif.out_data, exp_q[0]);
        end
        @(posedge clk);
        #1 sif.out_ready = 1'b1;
        tot = 0;
        for (int i = 0; i < 7; i++) begin
            send_word(32'ha5a50000 + 32'(i), 1'b0, '0, w);
            tot += w;
        end
        chk("burst_stalls", 32'(tot), 32'd0);
        drain();

        // init while waiting on block 4: old result must be discarded
        w = 0;
        while (n_starts < 4 && w < 100) begin
            w++;
            @(negedge clk);
        end
        chk("start4_seen", 32'(n_starts), 32'd4);
        repeat (3) @(posedge clk);
        #1;
        do_init(~k1, {32'hcafef00d, 32'h01234567, 32'h89abcdef}, 32'h10);
        for (int i = 0; i < 4; i++) send_word(32'h0f0f0f0f * (i + 1), 1'b0, '0, w);
        drain();
        chk("starts_rekey", 32'(n_starts), 32'd5);

        // Counter exhaustion
        do_init(k1 ^ {8{32'h5a5a5a5a}}, 96'h1, 32'hffffffff);
        for (int i = 0; i < 16; i++) send_word(32'h77770000 + 32'(i), 1'b0, '0, w);
        drain();
        chk("exh_flag", 32'(ctr_exhausted), 32'd1);
        chk("exh_blk_ctr", blk_ctr, 32'hffffffff);
        chk("exh_busy", 32'(busy), 32'd0);
        sif.in_valid = 1'b1;
        sif.in_data  = 32'h11111111;
        repeat (5) begin
            @(negedge clk);
            chk("exh_in_ready", 32'(sif.in_ready), 32'd0);
        end
        @(posedge clk);
        #1 sif.in_valid = 1'b0;
        chk("exh_starts", 32'(n_starts), 32'd6);
        do_init(k1, 96'h2, 32'd5);
        @(negedge clk);
        chk("reinit_exh_clear", 32'(ctr_exhausted), 32'd0);
        chk("reinit_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-stream
        send_word(32'hfeedface, 1'b0, '0, w);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(sif.out_valid), 32'd0);
        chk("arst_in_ready", 32'(sif.in_ready), 32'd0);
        chk("arst_core_start", 32'(core_start), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        starts_before = n_starts;
        repeat (30) @(negedge clk);
        chk("arst_no_start", 32'(n_starts), 32'(starts_before));
        chk("arst_idle", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        do_init(k1, 96'h3, 32'd9);
        send_word(32'h31415926, 1'b0, '0, w);
        drain();
        chk("recover_starts", 32'(n_starts), 32'(starts_before + 1));

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
